stack_ckpt: RTL
===============

// Module: stack_ckpt
// PURPOSE
//  Multi-port LIFO (up to PUSH pushes / POP pops per cycle) with pointer checkpoints
//  for speculative recovery, e.g. a return-address stack. Top POP entries are shown
//  ahead of pop; checkpoints snapshot {top pointer, count} and restore it on a mispredict.
// PARAMETERS
//  DATA   32  entry width
//  DEPTH  16  entries, power of 2, >= PUSH and >= POP
//  PUSH   2   push lanes per cycle
//  POP    2   pop lanes per cycle
//  CKPT   4   checkpoint slots, power of 2; TAG = $clog2(CKPT)
// PORTS
//  clk          in   1          clock
//  reset_       in   1          asynchronous active-low reset
//  flush_       in   1          sync clear of stack and checkpoints, active-low
//  push_        in   PUSH       per-lane push, active-low; lanes contiguous from lane 0
//  wd           in   PUSH*DATA  push data; lane 0 pushed first (ends deepest)
//  pop_         in   POP        per-lane pop, active-low; lanes contiguous from lane 0
//  rd           out  POP*DATA   rd[i] = entry at top-i; 0 when v[i]=0
//  v            out  POP        v[i] = (count > i)
//  busy         out  1          (DEPTH-count) < PUSH; tied 0 with wrap feature
//  save_        in   1          take checkpoint, active-low
//  save_tag     out  TAG        tag allocated by save_ this cycle (= alloc pointer)
//  restore_     in   1          restore checkpoint, active-low
//  restore_tag  in   TAG        checkpoint to restore
//  release_     in   1          free oldest checkpoint, active-low
//  ckpt_full    out  1          all CKPT slots valid
// BEHAVIOUR
//  - Reset/flush: count=0, top=0, all checkpoints invalid, alloc=oldest=0; v=0, rd=0,
//    busy=(PUSH>DEPTH)=0, ckpt_full=0, save_tag=0. Memory contents not cleared.
//  - Priority: reset_ > flush_ > restore_ > push/pop/save > release_.
//  - rd/v combinational from current state; pushed data visible next cycle (1-cycle).
//  - npop = number of asserted pop lanes with v=1 (pops past count ignored);
//    npush = asserted push lanes, or 0 if busy. Pops apply first, then pushes:
//    count' = count - npop + npush; top moves accordingly, modulo DEPTH.
//  - Same-cycle push+pop: popped lanes return old tops; pushed entries overwrite
//    the freed slots; e.g. count=3, 1 pop+1 push -> count stays 3, new top = wd[0].
//  - save_ (ignored if ckpt_full or restore_): slot[alloc] <= post-update {top,count},
//    valid; alloc++; save_tag = alloc before increment.
//  - restore_ with valid restore_tag: {top,count} <= slot; that slot and all younger
//    (restore_tag..alloc-1) invalidated; alloc <= restore_tag; same-cycle push/pop/save
//    dropped. Invalid tag: no-op. Only pointers restored; data overwritten after save is
//    not recovered (accepted RAS corruption).
//  - release_: invalidates slot[oldest], oldest++; no-op if none valid; ignored if
//    restore_ invalidates that slot in the same cycle.
//  - ckpt_full = all slots valid (alloc==oldest && slot[oldest] valid).
// CONFIGURATION
//  STACK_OVF_WRAP_EN defined: circular overflow; push at full overwrites oldest entry,
//    count saturates at DEPTH, busy tied 0 (RAS mode).
//  Not defined: push rejected in full when busy=1 (all lanes dropped, pops still
//    proceed); count never exceeds DEPTH; no data overwritten.
// TESTING
//  1 reset; push 1 lane 0xdeadbeef -> next cycle v=01, rd[0]=0xdeadbeef; pop 1 -> v=00.
//  2 push 2 lanes {A,A+1} x8 (DEPTH=16) -> count=16, busy=1; extra push ignored
//    (no _EN) / rd[0]=newest, count=16, oldest lost (with STACK_OVF_WRAP_EN).
//  3 count=3 (A,B,C top), pop 2 + push 1 D -> count=2, rd[0]=D, rd[1]=A.
//  4 count=2, save_ -> tag0; push X,Y; save_ -> tag1; restore tag0 -> count=2,
//    top unchanged, tag1 invalid, next save_ returns tag0.
//  5 4 saves -> ckpt_full=1; 5th save ignored; release_ -> ckpt_full=0, next tag=0.
//  6 pop on empty stack -> count stays 0; flush_ mid-stream with push -> count=0,
//    v=0, checkpoints cleared; reset_ asserted mid-push -> immediate clear.

Source files
------------

// File: rtl/stack_ckpt.sv
// Multi-port LIFO with {top, count} checkpoints for speculative recovery (return-address stack).
// Build option: STACK_OVF_WRAP_EN selects circular overflow (push at full overwrites the oldest entry).
module stack_ckpt #(
  parameter int DATA  = 32,
  parameter int DEPTH = 16,
  parameter int PUSH  = 2,
  parameter int POP   = 2,
  parameter int CKPT  = 4,
  parameter int TAG   = $clog2(CKPT)
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic                 flush_,
  input  logic [PUSH-1:0]      push_,
  input  logic [PUSH*DATA-1:0] wd,
  input  logic [POP-1:0]       pop_,
  output logic [POP*DATA-1:0]  rd,
  output logic [POP-1:0]       v,
  output logic                 busy,
  input  logic                 save_,
  output logic [TAG-1:0]       save_tag,
  input  logic                 restore_,
  input  logic [TAG-1:0]       restore_tag,
  input  logic                 release_,
  output logic                 ckpt_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA-1:0] mem [DEPTH];
  logic [PW-1:0]   top, top_pop, top_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic [PW-1:0]   slot_top [CKPT];
  logic [CW-1:0]   slot_cnt [CKPT];
  logic [CKPT-1:0] slot_v, slot_v_nxt, inv_mask;
  logic [TAG-1:0]  alloc, oldest;
  logic [TAG:0]    inv_span;

  logic [CW-1:0]   npop, npush;
  logic [PW-1:0]   wr_addr [PUSH];
  logic [PUSH-1:0] wr_en;
  logic            lane_on, restore_hit, do_save, do_release;

  // top points at the next free slot, so entry top-i lives at mem[top-1-i]
  for (genvar gi = 0; gi < POP; gi++) begin : g_rd
    logic [PW-1:0] rd_addr;
    assign v[gi]   = (count > CW'(gi));
    assign rd_addr = top - PW'(gi + 1);
    assign rd[gi*DATA +: DATA] = v[gi] ? mem[rd_addr] : '0;
  end

`ifdef STACK_OVF_WRAP_EN
  assign busy = 1'b0;
`else
  assign busy = (CW'(DEPTH) - count) < CW'(PUSH);
`endif

  assign restore_hit = !restore_ && slot_v[restore_tag];
  assign ckpt_full   = slot_v[oldest] && (alloc == oldest);
  assign do_save     = !save_ && restore_ && !ckpt_full;
  assign save_tag    = alloc;

  always_comb begin
    npop = '0;
    for (int i = 0; i < POP; i++)
      if (!pop_[i] && v[i]) npop = npop + CW'(1);
    top_pop = top - PW'(npop);
    npush   = '0;
    lane_on = 1'b0;
    for (int k = 0; k < PUSH; k++) begin
      lane_on    = !push_[k] && !busy;
      wr_addr[k] = top_pop + PW'(npush);
      wr_en[k]   = lane_on && flush_ && !restore_hit;
      if (lane_on) npush = npush + CW'(1);
    end
    top_nxt   = top_pop + PW'(npush);
    count_nxt = count - npop + npush;
`ifdef STACK_OVF_WRAP_EN
    if (count_nxt > CW'(DEPTH)) count_nxt = CW'(DEPTH);
`endif
  end

  // a restore frees its slot and every younger one; span 0 only occurs when all slots are live
  always_comb begin
    inv_span = {1'b0, alloc - restore_tag};
    if (inv_span == '0) inv_span = (TAG+1)'(CKPT);
    for (int j = 0; j < CKPT; j++)
      inv_mask[j] = restore_hit && ({1'b0, TAG'(j) - restore_tag} < inv_span);
    do_release = !release_ && slot_v[oldest] && !inv_mask[oldest];
    slot_v_nxt = slot_v & ~inv_mask;
    if (do_save)    slot_v_nxt[alloc]  = 1'b1;
    if (do_release) slot_v_nxt[oldest] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      top    <= '0;
      count  <= '0;
      slot_v <= '0;
      alloc  <= '0;
      oldest <= '0;
    end else if (!flush_) begin
      top    <= '0;
      count  <= '0;
      slot_v <= '0;
      alloc  <= '0;
      oldest <= '0;
    end else begin
      if (restore_hit) begin
        top   <= slot_top[restore_tag];
        count <= slot_cnt[restore_tag];
        alloc <= restore_tag;
      end else begin
        top   <= top_nxt;
        count <= count_nxt;
        if (do_save) alloc <= alloc + TAG'(1);
      end
      slot_v <= slot_v_nxt;
      if (do_release) oldest <= oldest + TAG'(1);
    end
  end

  // storage is not reset; only the pointers and valid bits define what is visible
  always_ff @(posedge clk) begin
    for (int k = 0; k < PUSH; k++)
      if (wr_en[k]) mem[wr_addr[k]] <= wd[k*DATA +: DATA];
    if (do_save && flush_) begin
      slot_top[alloc] <= top_nxt;
      slot_cnt[alloc] <= count_nxt;
    end
  end

endmodule
